// File: rtl/wb_mux_nport.sv
// wb_mux_nport: Wishbone classic 1-master / NUM_SLAVES-slave address decoder and mux.
//
// A master cycle is decoded against per-slave (prefix, mask) pairs while
// IDLE; the lowest matching index is latched and the FSM routes the cycle to
// that slave only (ACTIVE). An unmapped access produces a one-cycle error
// (ERROR). Address, data and byte selects are broadcast to every slave;
// cyc/stb/we and the response path belong to the latched slave alone.
//
// Optional feature: define WB_MUX_NPORT_TIMEOUT_EN to compile in a watchdog
// that aborts an ACTIVE cycle after TIMEOUT_CYCLES clocks without a slave
// response and returns a one-cycle master error.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   wbm_*_i / wbm_*_o            master-side Wishbone classic port
//   wbs_*_o / wbs_*_i            slave-side ports, packed, slave k in slice k
//   wbs_addr, wbs_addr_msk       per-slave address prefix and prefix mask
//   busy_o                       high while the FSM is not IDLE
module wb_mux_nport #(
  parameter int NUM_SLAVES     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               clk,
  input  logic                               rst_n,
  // master side
  input  logic [ADDR_WIDTH-1:0]              wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]              wbm_dat_i,
  input  logic                               wbm_we_i,
  input  logic [SELECT_WIDTH-1:0]            wbm_sel_i,
  input  logic                               wbm_stb_i,
  input  logic                               wbm_cyc_i,
  output logic [DATA_WIDTH-1:0]              wbm_dat_o,
  output logic                               wbm_ack_o,
  output logic                               wbm_err_o,
  output logic                               wbm_rty_o,
  // slave side
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0]   wbs_adr_o,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0]   wbs_dat_o,
  output logic [NUM_SLAVES-1:0]              wbs_we_o,
  output logic [NUM_SLAVES*SELECT_WIDTH-1:0] wbs_sel_o,
  output logic [NUM_SLAVES-1:0]              wbs_stb_o,
  output logic [NUM_SLAVES-1:0]              wbs_cyc_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]              wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]              wbs_err_i,
  input  logic [NUM_SLAVES-1:0]              wbs_rty_i,
  // address map
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0]   wbs_addr,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0]   wbs_addr_msk,
  // status
  output logic                               busy_o
);

  localparam int IDX_W = $clog2(NUM_SLAVES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             busy_q;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             active;
  logic             live;
  logic             sel_ack;
  logic             sel_err;
  logic             sel_rty;
  logic             resp;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic             tmo_hit;

`ifdef WB_MUX_NPORT_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q;
`endif

  // Address decode; first match in ascending order wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (!hit &&
          (((wbm_adr_i ^ wbs_addr[k*ADDR_WIDTH +: ADDR_WIDTH]) &
            wbs_addr_msk[k*ADDR_WIDTH +: ADDR_WIDTH]) == '0)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
  end

  assign active  = (state_q == ST_ACTIVE);
  // Slave strobes are gated by the live master cyc so a cyc drop takes
  // effect in the same cycle, before the FSM leaves ACTIVE.
  assign live    = active & wbm_cyc_i;

  assign sel_ack = wbs_ack_i[idx_q];
  assign sel_err = wbs_err_i[idx_q];
  assign sel_rty = wbs_rty_i[idx_q];
  assign sel_dat = wbs_dat_i[idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign resp    = sel_ack | sel_err | sel_rty;

`ifdef WB_MUX_NPORT_TIMEOUT_EN
  // A response in the final watchdog cycle wins over the timeout.
  assign tmo_hit = live & ~resp & (tmo_cnt_q == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  // Broadcast fields.
  assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
  assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
  assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};

  // Per-slave control: only the latched slave sees the master cycle.
  always_comb begin
    wbs_cyc_o = '0;
    wbs_stb_o = '0;
    wbs_we_o  = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (live && (idx_q == IDX_W'(k))) begin
        wbs_cyc_o[k] = 1'b1;
        wbs_stb_o[k] = wbm_stb_i;
        wbs_we_o[k]  = wbm_we_i;
      end
    end
  end

  // Master response path.
  assign wbm_ack_o = live & sel_ack;
  assign wbm_rty_o = live & sel_rty;
  assign wbm_err_o = (live & sel_err) | (state_q == ST_ERROR);
  assign wbm_dat_o = live ? sel_dat : '0;

  assign busy_o = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
`ifdef WB_MUX_NPORT_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wbm_cyc_i && wbm_stb_i) begin
            busy_q <= 1'b1;
            if (hit) begin
              idx_q   <= hit_idx;
              state_q <= ST_ACTIVE;
`ifdef WB_MUX_NPORT_TIMEOUT_EN
              tmo_cnt_q <= '0;
`endif
            end else begin
              state_q <= ST_ERROR;
            end
          end
        end
        ST_ACTIVE: begin
          if (!wbm_cyc_i || resp) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (tmo_hit) begin
            state_q <= ST_ERROR;
          end else begin
`ifdef WB_MUX_NPORT_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
`endif
          end
        end
        ST_ERROR: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mux_nport.sv
// Directed bench for wb_mux_nport (4 slaves, 32-bit bus, TIMEOUT_CYCLES=8).
// Address map: s0 0x0000/0xF000, s1 0x3000/0xF000, s2 0x2000/0xF000,
// s3 0x3000/0xFF00 (overlaps s1). Inputs driven on the falling edge,
// outputs sampled 1 ns later.
module tb_wb_mux_nport;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [AW-1:0]     wbm_adr_i;
  logic [DW-1:0]     wbm_dat_i;
  logic              wbm_we_i;
  logic [SW-1:0]     wbm_sel_i;
  logic              wbm_stb_i;
  logic              wbm_cyc_i;
  logic [DW-1:0]     wbm_dat_o;
  logic              wbm_ack_o;
  logic              wbm_err_o;
  logic              wbm_rty_o;
  logic [N*AW-1:0]   wbs_adr_o;
  logic [N*DW-1:0]   wbs_dat_o;
  logic [N-1:0]      wbs_we_o;
  logic [N*SW-1:0]   wbs_sel_o;
  logic [N-1:0]      wbs_stb_o;
  logic [N-1:0]      wbs_cyc_o;
  logic [N*DW-1:0]   wbs_dat_i;
  logic [N-1:0]      wbs_ack_i;
  logic [N-1:0]      wbs_err_i;
  logic [N-1:0]      wbs_rty_i;
  logic [N*AW-1:0]   wbs_addr;
  logic [N*AW-1:0]   wbs_addr_msk;
  logic              busy_o;

  int unsigned vec_cnt  = 0;
  int unsigned miss_cnt = 0;

  wb_mux_nport #(
    .NUM_SLAVES     (N),
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .SELECT_WIDTH   (SW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wbm_adr_i    (wbm_adr_i),
    .wbm_dat_i    (wbm_dat_i),
    .wbm_we_i     (wbm_we_i),
    .wbm_sel_i    (wbm_sel_i),
    .wbm_stb_i    (wbm_stb_i),
    .wbm_cyc_i    (wbm_cyc_i),
    .wbm_dat_o    (wbm_dat_o),
    .wbm_ack_o    (wbm_ack_o),
    .wbm_err_o    (wbm_err_o),
    .wbm_rty_o    (wbm_rty_o),
    .wbs_adr_o    (wbs_adr_o),
    .wbs_dat_o    (wbs_dat_o),
    .wbs_we_o     (wbs_we_o),
    .wbs_sel_o    (wbs_sel_o),
    .wbs_stb_o    (wbs_stb_o),
    .wbs_cyc_o    (wbs_cyc_o),
    .wbs_dat_i    (wbs_dat_i),
    .wbs_ack_i    (wbs_ack_i),
    .wbs_err_i    (wbs_err_i),
    .wbs_rty_i    (wbs_rty_i),
    .wbs_addr     (wbs_addr),
    .wbs_addr_msk (wbs_addr_msk),
    .busy_o       (busy_o)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic master_req(input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] dat);
    wbm_adr_i = adr;
    wbm_we_i  = we;
    wbm_dat_i = dat;
    wbm_sel_i = 4'hF;
    wbm_cyc_i = 1'b1;
    wbm_stb_i = 1'b1;
  endtask

  task automatic master_idle();
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    wbm_we_i  = 1'b0;
  endtask

  task automatic slave_quiet();
    wbs_ack_i = '0;
    wbs_err_i = '0;
    wbs_rty_i = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    master_idle();
    slave_quiet();
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0;
    wbs_dat_i = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    wbs_addr     = {32'h0000_3000, 32'h0000_2000, 32'h0000_3000, 32'h0000_0000};
    wbs_addr_msk = {32'h0000_FF00, 32'h0000_F000, 32'h0000_F000, 32'h0000_F000};
    #1;
    if (busy_o !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", busy_o); miss_cnt++; end vec_cnt++;
    if (wbs_cyc_o !== 4'b0000) begin $display("FAIL rst_cyc: got %b want 0000", wbs_cyc_o); miss_cnt++; end vec_cnt++;
    if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b000) begin $display("FAIL rst_resp: got %b want 000", {wbm_ack_o, wbm_err_o, wbm_rty_o}); miss_cnt++; end vec_cnt++;
    if (wbm_dat_o !== 32'h0) begin $display("FAIL rst_dat: got %h want 0", wbm_dat_o); miss_cnt++; end vec_cnt++;
    step(); step();
    rst_n = 1'b1;
    step(); #1;
    if (busy_o !== 1'b0) begin $display("FAIL post_rst_busy: got %b want 0", busy_o); miss_cnt++; end vec_cnt++;
  endtask

  // Slave 2 acks 3 cycles after it first sees stb: master ack 4 cycles after stb.
  task automatic test_decode_read();
    step(); master_req(32'h0000_2004, 1'b0, 32'h0); #1;
    if (busy_o !== 1'b0) begin $display("FAIL rd_decode_busy: got %b want 0", busy_o); miss_cnt++; end vec_cnt++;
    if (wbs_cyc_o !== 4'b0000) begin $display("FAIL rd_decode_cyc: got %b want 0000", wbs_cyc_o); miss_cnt++; end vec_cnt++;
    for (int i = 1; i <= 3; i++) begin
      step(); #1;
      if (wbs_cyc_o !== 4'b0100) begin $display("FAIL rd_cyc c%0d: got %b want 0100", i, wbs_cyc_o); miss_cnt++; end vec_cnt++;
      if (wbs_stb_o !== 4'b0100) begin $display("FAIL rd_stb c%0d: got %b want 0100", i, wbs_stb_o); miss_cnt++; end vec_cnt++;
      if (wbm_ack_o !== 1'b0) begin $display("FAIL rd_early_ack c%0d: got %b want 0", i, wbm_ack_o); miss_cnt++; end vec_cnt++;
      if (busy_o !== 1'b1) begin $display("FAIL rd_busy c%0d: got %b want 1", i, busy_o); miss_cnt++; end vec_cnt++;
    end
    step(); wbs_ack_i = 4'b0100; wbs_dat_i[95:64] = 32'hDEAD_BEEF; #1;
    if (wbm_ack_o !== 1'b1) begin $display("FAIL rd_ack: got %b want 1", wbm_ack_o); miss_cnt++; end vec_cnt++;
    if (wbm_dat_o !== 32'hDEAD_BEEF) begin $display("FAIL rd_dat: got %h want deadbeef", wbm_dat_o); miss_cnt++; end vec_cnt++;
    step(); master_idle(); slave_quiet(); #1;
    if (busy_o !== 1'b0) begin $display("FAIL rd_done_busy: got %b want 0", busy_o); miss_cnt++; end vec_cnt++;
    if (wbm_dat_o !== 32'h0) begin $display("FAIL rd_idle_dat: got %h want 0", wbm_dat_o); miss_cnt++; end vec_cnt++;
  endtask

  // 0x3000 matches slaves 1 and 3; slave 1 wins. Single-cycle ack, write broadcast.
  task automatic test_overlap_write();
    step(); master_req(32'h0000_3000, 1'b1, 32'hA5A5_0F0F);
    step(); wbs_ack_i = 4'b0010; #1;
    if (wbs_cyc_o !== 4'b0010) begin $display("FAIL ov_cyc: got %b want 0010", wbs_cyc_o); miss_cnt++; end vec_cnt++;
    if (wbs_we_o !== 4'b0010) begin $display("FAIL ov_we: got %b want 0010", wbs_we_o); miss_cnt++; end vec_cnt++;
    if (wbs_dat_o !== {4{32'hA5A5_0F0F}}) begin $display("FAIL ov_dat_bcast: got %h want %h", wbs_dat_o, {4{32'hA5A5_0F0F}}); miss_cnt++; end vec_cnt++;
    if (wbs_adr_o !== {4{32'h0000_3000}}) begin $display("FAIL ov_adr_bcast: got %h want %h", wbs_adr_o, {4{32'h0000_3000}}); miss_cnt++; end vec_cnt++;
    if (wbm_ack_o !== 1'b1) begin $display("FAIL ov_ack: got %b want 1", wbm_ack_o); miss_cnt++; end vec_cnt++;
    step(); master_idle(); slave_quiet(); #1;
    if (busy_o !== 1'b0) begin $display("FAIL ov_done_busy: got %b want 0", busy_o); miss_cnt++; end vec_cnt++;
  endtask

  task automatic test_unmapped();
    step(); master_req(32'h0000_F000, 1'b0, 32'h0); #1;
    if (wbm_err_o !== 1'b0) begin $display("FAIL um_early_err: got %b want 0", wbm_err_o); miss_cnt++; end vec_cnt++;
    step(); master_idle(); #1;
    if (wbm_err_o !== 1'b1) begin $display("FAIL um_err: got %b want 1", wbm_err_o); miss_cnt++; end vec_cnt++;
    if (busy_o !== 1'b1) begin $display("FAIL um_busy: got %b want 1", busy_o); miss_cnt++; end vec_cnt++;
    if (wbs_cyc_o !== 4'b0000) begin $display("FAIL um_cyc: got %b want 0000", wbs_cyc_o); miss_cnt++; end vec_cnt++;
    step(); #1;
    if (wbm_err_o !== 1'b0) begin $display("FAIL um_err_len: got %b want 0", wbm_err_o); miss_cnt++; end vec_cnt++;
    if (busy_o !== 1'b0) begin $display("FAIL um_idle: got %b want 0", busy_o); miss_cnt++; end vec_cnt++;
  endtask

  // Other slaves' responses are ignored; map changes mid-cycle do not move the latch.
  task automatic test_spurious();
    step(); master_req(32'h0000_3004, 1'b0, 32'h0);
    wbs_dat_i[31:0] = 32'hBAD0_0000; wbs_dat_i[63:32] = 32'h1234_5678;
    for (int i = 1; i <= 2; i++) begin
      step(); wbs_ack_i = 4'b0001; wbs_err_i = 4'b0100; wbs_addr[63:32] = 32'h0000_7000; #1;
      if (wbm_ack_o !== 1'b0) begin $display("FAIL sp_ack c%0d: got %b want 0", i, wbm_ack_o); miss_cnt++; end vec_cnt++;
      if (wbm_err_o !== 1'b0) begin $display("FAIL sp_err c%0d: got %b want 0", i, wbm_err_o); miss_cnt++; end vec_cnt++;
      if (wbs_cyc_o !== 4'b0010) begin $display("FAIL sp_cyc c%0d: got %b want 0010", i, wbs_cyc_o); miss_cnt++; end vec_cnt++;
    end
    step(); wbs_ack_i = 4'b0010; wbs_err_i = 4'b0000; #1;
    if (wbm_ack_o !== 1'b1) begin $display("FAIL sp_real_ack: got %b want 1", wbm_ack_o); miss_cnt++; end vec_cnt++;
    if (wbm_dat_o !== 32'h1234_5678) begin $display("FAIL sp_dat: got %h want 12345678", wbm_dat_o); miss_cnt++; end vec_cnt++;
    step(); master_idle(); slave_quiet(); wbs_addr[63:32] = 32'h0000_3000; #1;
    if (busy_o !== 1'b0) begin $display("FAIL sp_done_busy: got %b want 0", busy_o); miss_cnt++; end vec_cnt++;
  endtask

  task automatic test_err_rty();
    step(); master_req(32'h0000_2000, 1'b0, 32'h0);
    step(); wbs_err_i = 4'b0100; #1;
    if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b010) begin $display("FAIL serr_resp: got %b want 010", {wbm_ack_o, wbm_err_o, wbm_rty_o}); miss_cnt++; end vec_cnt++;
    step(); master_idle(); slave_quiet(); #1;
    if (busy_o !== 1'b0) begin $display("FAIL serr_busy: got %b want 0", busy_o); miss_cnt++; end vec_cnt++;
    step(); master_req(32'h0000_0010, 1'b0, 32'h0);
    step(); wbs_rty_i = 4'b0001; #1;
    if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b001) begin $display("FAIL srty_resp: got %b want 001", {wbm_ack_o, wbm_err_o, wbm_rty_o}); miss_cnt++; end vec_cnt++;
    step(); master_idle(); slave_quiet(); #1;
    if (busy_o !== 1'b0) begin $display("FAIL srty_busy: got %b want 0", busy_o); miss_cnt++; end vec_cnt++;
  endtask

  task automatic test_cyc_drop();
    step(); master_req(32'h0000_2008, 1'b0, 32'h0);
    step(); #1;
    if (wbs_cyc_o !== 4'b0100) begin $display("FAIL cd_cyc: got %b want 0100", wbs_cyc_o); miss_cnt++; end vec_cnt++;
    step(); master_idle(); wbs_ack_i = 4'b0100; #1;
    if (wbs_cyc_o !== 4'b0000) begin $display("FAIL cd_cyc_gated: got %b want 0000", wbs_cyc_o); miss_cnt++; end vec_cnt++;
    if (wbm_ack_o !== 1'b0) begin $display("FAIL cd_ack: got %b want 0", wbm_ack_o); miss_cnt++; end vec_cnt++;
    step(); slave_quiet(); #1;
    if (busy_o !== 1'b0) begin $display("FAIL cd_busy: got %b want 0", busy_o); miss_cnt++; end vec_cnt++;
    if (wbm_err_o !== 1'b0) begin $display("FAIL cd_err: got %b want 0", wbm_err_o); miss_cnt++; end vec_cnt++;
  endtask

  task automatic test_back_to_back();
    step(); master_req(32'h0000_2000, 1'b0, 32'h0);
    step(); wbs_ack_i = 4'b0100; #1;
    if (wbm_ack_o !== 1'b1) begin $display("FAIL b2b_ack1: got %b want 1", wbm_ack_o); miss_cnt++; end vec_cnt++;
    step(); slave_quiet(); wbm_adr_i = 32'h0000_3000; #1;
    if (busy_o !== 1'b0) begin $display("FAIL b2b_gap_busy: got %b want 0", busy_o); miss_cnt++; end vec_cnt++;
    if (wbs_cyc_o !== 4'b0000) begin $display("FAIL b2b_gap_cyc: got %b want 0000", wbs_cyc_o); miss_cnt++; end vec_cnt++;
    step(); #1;
    if (wbs_cyc_o !== 4'b0010) begin $display("FAIL b2b_cyc2: got %b want 0010", wbs_cyc_o); miss_cnt++; end vec_cnt++;
    step(); wbs_ack_i = 4'b0010; #1;
    if (wbm_ack_o !== 1'b1) begin $display("FAIL b2b_ack2: got %b want 1", wbm_ack_o); miss_cnt++; end vec_cnt++;
    step(); master_idle(); slave_quiet();
  endtask

`ifdef WB_MUX_NPORT_TIMEOUT_EN
  task automatic test_timeout();
    step(); master_req(32'h0000_2000, 1'b0, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      step(); #1;
      if (wbs_cyc_o !== 4'b0100) begin $display("FAIL to_cyc c%0d: got %b want 0100", i, wbs_cyc_o); miss_cnt++; end vec_cnt++;
      if (wbm_err_o !== 1'b0) begin $display("FAIL to_early_err c%0d: got %b want 0", i, wbm_err_o); miss_cnt++; end vec_cnt++;
    end
    step(); master_idle(); #1;
    if (wbm_err_o !== 1'b1) begin $display("FAIL to_err: got %b want 1", wbm_err_o); miss_cnt++; end vec_cnt++;
    if (wbs_cyc_o !== 4'b0000) begin $display("FAIL to_cyc_drop: got %b want 0000", wbs_cyc_o); miss_cnt++; end vec_cnt++;
    step(); #1;
    if ({busy_o, wbm_err_o} !== 2'b00) begin $display("FAIL to_idle: got %b want 00", {busy_o, wbm_err_o}); miss_cnt++; end vec_cnt++;
    step(); master_req(32'h0000_2000, 1'b0, 32'h0);
    for (int i = 1; i <= 7; i++) step();
    step(); wbs_ack_i = 4'b0100; #1;
    if ({wbm_ack_o, wbm_err_o} !== 2'b10) begin $display("FAIL to_last_ack: got %b want 10", {wbm_ack_o, wbm_err_o}); miss_cnt++; end vec_cnt++;
    step(); master_idle(); slave_quiet(); #1;
    if ({busy_o, wbm_err_o} !== 2'b00) begin $display("FAIL to_last_idle: got %b want 00", {busy_o, wbm_err_o}); miss_cnt++; end vec_cnt++;
  endtask
`else
  task automatic test_no_timeout();
    step(); master_req(32'h0000_2000, 1'b0, 32'h0);
    for (int i = 1; i <= 20; i++) step();
    #1;
    if ({busy_o, wbs_cyc_o, wbm_err_o} !== {1'b1, 4'b0100, 1'b0}) begin $display("FAIL nto_stall: got %b want 101000", {busy_o, wbs_cyc_o, wbm_err_o}); miss_cnt++; end vec_cnt++;
    step(); wbs_ack_i = 4'b0100; #1;
    if (wbm_ack_o !== 1'b1) begin $display("FAIL nto_ack: got %b want 1", wbm_ack_o); miss_cnt++; end vec_cnt++;
    step(); master_idle(); slave_quiet();
  endtask
`endif

  task automatic test_reset_mid();
    step(); master_req(32'h0000_2000, 1'b0, 32'h0);
    step(); #1;
    if (wbs_cyc_o !== 4'b0100) begin $display("FAIL rm_cyc: got %b want 0100", wbs_cyc_o); miss_cnt++; end vec_cnt++;
    #1; wbs_ack_i = 4'b0100; rst_n = 1'b0; #1;
    if ({wbs_cyc_o, wbs_stb_o} !== 8'h00) begin $display("FAIL rm_slave: got %b want 00000000", {wbs_cyc_o, wbs_stb_o}); miss_cnt++; end vec_cnt++;
    if ({wbm_ack_o, wbm_err_o} !== 2'b00) begin $display("FAIL rm_resp: got %b want 00", {wbm_ack_o, wbm_err_o}); miss_cnt++; end vec_cnt++;
    if (busy_o !== 1'b0) begin $display("FAIL rm_busy: got %b want 0", busy_o); miss_cnt++; end vec_cnt++;
    step(); master_idle(); slave_quiet(); rst_n = 1'b1;
    step(); master_req(32'h0000_2004, 1'b0, 32'h0); #1;
    if (busy_o !== 1'b0) begin $display("FAIL rm_rel_busy: got %b want 0", busy_o); miss_cnt++; end vec_cnt++;
    step(); wbs_ack_i = 4'b0100; wbs_dat_i[95:64] = 32'hCAFE_F00D; #1;
    if (wbm_dat_o !== 32'hCAFE_F00D || wbm_ack_o !== 1'b1) begin $display("FAIL rm_recover: got ack %b dat %h want ack 1 dat cafef00d", wbm_ack_o, wbm_dat_o); miss_cnt++; end vec_cnt++;
    step(); master_idle(); slave_quiet();
  endtask

  initial begin
    test_reset();
    test_decode_read();
    test_overlap_write();
    test_unmapped();
    test_spurious();
    test_err_rty();
    test_cyc_drop();
    test_back_to_back();
`ifdef WB_MUX_NPORT_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
